arp_sequencer: RTL and testbench

//  Arpeggiator/scheduler in front of the note_lut -> tone_gen path. Scans the 12 held keys and

---
 rtl/arp_sequencer_if.sv | 31 +++
 rtl/arp_sequencer.sv | 233 +++++++++++++++++++++++
 tb/tb_arp_sequencer.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/arp_sequencer_if.sv
// ============================================================================
// Module      : arp_sequencer_if
// Description : Control and note-output bundle between the key scanner side and
//               the arpeggiator (arp_sequencer -> note_lut path).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface arp_sequencer_if;
   logic        ena;
   logic [11:0] keys;
   logic [3:0]  octave_in;
   logic [7:0]  tempo;
   logic [1:0]  mode;
   logic [3:0]  note;
   logic [3:0]  octave;
   logic        gate;
   logic        step_stb;

   modport master (
      output ena, keys, octave_in, tempo, mode,
      input  note, octave, gate, step_stb
   );

   modport slave (
      input  ena, keys, octave_in, tempo, mode,
      output note, octave, gate, step_stb
   );
endinterface

`default_nettype wire

// File: rtl/arp_sequencer.sv
// ============================================================================
// Module      : arp_sequencer
// Description : Arpeggiator; plays held keys one at a time at a programmable
//               step rate. Optional two-octave span: OCTAVE_SPAN_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module arp_sequencer #(
   parameter int PRESCALE = 1000,
   parameter int GAP      = 8
) (
   input  logic           clk,
   input  logic           rst_n,
   arp_sequencer_if.slave bus
);

   localparam int         c_PRE_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [3:0] c_SILENT = 4'hF;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_STEP = 1'b1
   } state_t;

   state_t              r_state, w_nxt_state;
   logic [11:0]         r_key_q;
   logic [c_PRE_W-1:0]  r_presc, w_nxt_presc;
   logic [7:0]          r_step, w_nxt_step;
   logic [7:0]          r_tempo_q, w_nxt_tempo;
   logic [3:0]          r_cur, w_nxt_cur;
   logic [3:0]          r_note, w_nxt_note;
   logic [3:0]          r_octave, w_nxt_octave;
   logic                r_gate_en, w_nxt_gate_en;
   logic                r_stb, w_nxt_stb;
   logic                r_dir_up, w_nxt_dir_up;

   logic [11:0]         w_held;
   logic [3:0]          w_lo_all, w_hi_all, w_above, w_below;
   logic                w_has_above, w_has_below;
   logic [3:0]          w_sel_note;
   logic                w_sel_dir_up;
   logic                w_last_tick, w_step_end, w_gap;
   logic [3:0]          w_step_oct;

   // Bit-reverse so that index equals note code (bit 11 of keys is C).
   assign w_held = {<<{r_key_q}};

   always_comb begin
      w_lo_all    = 4'd0;
      w_hi_all    = 4'd0;
      w_above     = 4'd0;
      w_below     = 4'd0;
      w_has_above = 1'b0;
      w_has_below = 1'b0;
      for (int i = 11; i >= 0; i--) begin
         if (w_held[i]) begin
            w_lo_all = 4'(i);
            if (4'(i) > r_cur) begin
               w_above     = 4'(i);
               w_has_above = 1'b1;
            end
         end
      end
      for (int i = 0; i < 12; i++) begin
         if (w_held[i]) begin
            w_hi_all = 4'(i);
            if (4'(i) < r_cur) begin
               w_below     = 4'(i);
               w_has_below = 1'b1;
            end
         end
      end
   end

   // Search starts from r_cur even if that key is no longer held.
   always_comb begin
      w_sel_note   = w_lo_all;
      w_sel_dir_up = r_dir_up;
      case (bus.mode)
         2'd0: w_sel_note = w_has_above ? w_above : w_lo_all;
         2'd1: w_sel_note = w_has_below ? w_below : w_hi_all;
         2'd2: begin
            if (r_dir_up) begin
               if (w_has_above) begin
                  w_sel_note = w_above;
               end else if (w_has_below) begin
                  w_sel_note   = w_below;
                  w_sel_dir_up = 1'b0;
               end else begin
                  w_sel_note = r_cur;
               end
            end else begin
               if (w_has_below) begin
                  w_sel_note = w_below;
               end else if (w_has_above) begin
                  w_sel_note   = w_above;
                  w_sel_dir_up = 1'b1;
               end else begin
                  w_sel_note = r_cur;
               end
            end
         end
         default: w_sel_note = w_lo_all;
      endcase
   end

   assign w_last_tick = (int'(r_presc) == PRESCALE - 1);
   assign w_step_end  = w_last_tick && (r_step == r_tempo_q);
   // GAP < PRESCALE, so the articulation gap always lies inside the final tick.
   assign w_gap       = (r_step == r_tempo_q) && (int'(r_presc) >= PRESCALE - GAP);

`ifdef OCTAVE_SPAN_EN
   logic       r_oct_off;
   logic       w_wrap;
   logic       w_off_used;
   logic [4:0] w_oct_sum;

   // Wrap in up/down, or the down->up turn that completes a bounce cycle.
   assign w_wrap = ((bus.mode == 2'd0) && !w_has_above) ||
                   ((bus.mode == 2'd1) && !w_has_below) ||
                   ((bus.mode == 2'd2) && !r_dir_up && !w_has_below && w_has_above);

   assign w_off_used = (bus.mode == 2'd3) ? 1'b0 : (r_oct_off ^ w_wrap);
   assign w_oct_sum  = {1'b0, bus.octave_in} + {4'd0, w_off_used};
   assign w_step_oct = w_oct_sum[4] ? 4'hF : w_oct_sum[3:0];

   always_ff @(posedge clk) begin
      if (!rst_n || !bus.ena) begin
         r_oct_off <= 1'b0;
      end else if (r_state == S_IDLE) begin
         r_oct_off <= 1'b0;
      end else if (w_step_end) begin
         r_oct_off <= (r_key_q != 12'd0) ? (r_oct_off ^ w_wrap) : 1'b0;
      end
   end
`else
   assign w_step_oct = bus.octave_in;
`endif

   always_comb begin
      w_nxt_state   = r_state;
      w_nxt_presc   = r_presc;
      w_nxt_step    = r_step;
      w_nxt_tempo   = r_tempo_q;
      w_nxt_cur     = r_cur;
      w_nxt_note    = r_note;
      w_nxt_octave  = r_octave;
      w_nxt_gate_en = r_gate_en;
      w_nxt_stb     = 1'b0;
      w_nxt_dir_up  = r_dir_up;
      case (r_state)
         S_IDLE: begin
            w_nxt_presc   = '0;
            w_nxt_step    = 8'd0;
            w_nxt_note    = c_SILENT;
            w_nxt_gate_en = 1'b0;
            w_nxt_dir_up  = 1'b1;
            w_nxt_octave  = bus.octave_in;
            if (r_key_q != 12'd0) begin
               w_nxt_state   = S_STEP;
               w_nxt_cur     = (bus.mode == 2'd1) ? w_hi_all : w_lo_all;
               w_nxt_note    = (bus.mode == 2'd1) ? w_hi_all : w_lo_all;
               w_nxt_gate_en = 1'b1;
               w_nxt_stb     = 1'b1;
               w_nxt_tempo   = bus.tempo;
            end
         end
         S_STEP: begin
            if (w_step_end) begin
               w_nxt_presc = '0;
               w_nxt_step  = 8'd0;
               if (r_key_q == 12'd0) begin
                  w_nxt_state   = S_IDLE;
                  w_nxt_note    = c_SILENT;
                  w_nxt_gate_en = 1'b0;
                  w_nxt_dir_up  = 1'b1;
                  w_nxt_octave  = bus.octave_in;
               end else begin
                  w_nxt_cur     = w_sel_note;
                  w_nxt_note    = w_sel_note;
                  w_nxt_dir_up  = w_sel_dir_up;
                  w_nxt_gate_en = 1'b1;
                  w_nxt_stb     = 1'b1;
                  w_nxt_tempo   = bus.tempo;
                  w_nxt_octave  = w_step_oct;
               end
            end else if (w_last_tick) begin
               w_nxt_presc = '0;
               w_nxt_step  = r_step + 8'd1;
            end else begin
               w_nxt_presc = r_presc + 1'b1;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n || !bus.ena) begin
         r_state   <= S_IDLE;
         r_key_q   <= 12'd0;
         r_presc   <= '0;
         r_step    <= 8'd0;
         r_tempo_q <= 8'd0;
         r_cur     <= 4'd0;
         r_note    <= c_SILENT;
         r_octave  <= bus.octave_in;
         r_gate_en <= 1'b0;
         r_stb     <= 1'b0;
         r_dir_up  <= 1'b1;
      end else begin
         r_state   <= w_nxt_state;
         r_key_q   <= bus.keys;
         r_presc   <= w_nxt_presc;
         r_step    <= w_nxt_step;
         r_tempo_q <= w_nxt_tempo;
         r_cur     <= w_nxt_cur;
         r_note    <= w_nxt_note;
         r_octave  <= w_nxt_octave;
         r_gate_en <= w_nxt_gate_en;
         r_stb     <= w_nxt_stb;
         r_dir_up  <= w_nxt_dir_up;
      end
   end

   assign bus.note     = r_note;
   assign bus.octave   = r_octave;
   assign bus.gate     = r_gate_en & ~w_gap;
   assign bus.step_stb = r_stb;

endmodule

`default_nettype wire

// File: tb/tb_arp_sequencer.sv
// ============================================================================
// Module      : tb_arp_sequencer
// Description : Directed self-checking bench for arp_sequencer (PRESCALE=4, GAP=1).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_arp_sequencer;

   localparam int c_GAP = 1;

   logic clk = 1'b0;
   logic rst_n;
   int   n_checks = 0;
   int   n_fail   = 0;

   arp_sequencer_if bus ();

   arp_sequencer #(
      .PRESCALE (4),
      .GAP      (c_GAP)
   ) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Advance until the next strobe; len = cycles taken, lows = gate-low samples before it.
   task automatic run_step(output int len, output int lows, output logic lastg);
      len   = 0;
      lows  = 0;
      lastg = 1'b1;
      while (len < 64) begin
         tick();
         len++;
         if (bus.step_stb === 1'b1) return;
         lastg = bus.gate;
         if (bus.gate !== 1'b1) lows++;
      end
      check_val("stb_timeout", {31'd0, bus.step_stb}, 32'd1);
   endtask

   task automatic step_check(input string tag, input int exp_note, input int exp_len, input int exp_oct);
      int   len, lows;
      logic lastg;
      run_step(len, lows, lastg);
      check_val({tag, "_note"}, {28'd0, bus.note}, exp_note);
      if (exp_len > 0) begin
         check_val({tag, "_len"},   len, exp_len);
         check_val({tag, "_gaplen"}, lows, c_GAP);
         check_val({tag, "_lastgate"}, {31'd0, lastg}, 32'd0);
         check_val({tag, "_gate"}, {31'd0, bus.gate}, 32'd1);
      end
      if (exp_oct >= 0) check_val({tag, "_oct"}, {28'd0, bus.octave}, exp_oct);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int   len, lows, nstb;
      logic lastg;
      int   oct6[6];

      rst_n         = 1'b0;
      bus.ena       = 1'b1;
      bus.keys      = 12'hFFF;
      bus.octave_in = 4'd4;
      bus.tempo     = 8'd1;
      bus.mode      = 2'd0;

      // Test 1: reset and first-note latency
      tick();
      tick();
      check_val("rst_note", {28'd0, bus.note}, 32'hF);
      check_val("rst_gate", {31'd0, bus.gate}, 32'd0);
      check_val("rst_stb",  {31'd0, bus.step_stb}, 32'd0);
      check_val("rst_oct",  {28'd0, bus.octave}, 32'd4);
      rst_n = 1'b1;
      tick();
      check_val("lat_edge1_stb", {31'd0, bus.step_stb}, 32'd0);
      tick();
      check_val("lat_edge2_stb", {31'd0, bus.step_stb}, 32'd1);
      check_val("lat_note", {28'd0, bus.note}, 32'd0);
      check_val("lat_gate", {31'd0, bus.gate}, 32'd1);

      // Test 2: up mode, C E G
      bus.keys = 12'h890;
      step_check("up0", 4, 8, -1);
      step_check("up1", 7, 8, -1);
      step_check("up2", 0, 8, -1);

      // Test 3: up-down then down
      bus.mode = 2'd2;
      step_check("ud0", 4, 8, -1);
      step_check("ud1", 7, 8, -1);
      step_check("ud2", 4, 8, -1);
      step_check("ud3", 0, 8, -1);
      step_check("ud4", 4, 8, -1);
      bus.mode = 2'd1;
      step_check("dn0", 0, 8, -1);
      step_check("dn1", 7, 8, -1);
      step_check("dn2", 4, 8, -1);

      // Test 4: single key A repeats, then release mid-step
      bus.mode = 2'd0;
      bus.keys = 12'h004;
      step_check("one0", 9, 8, -1);
      step_check("one1", 9, 8, -1);
      tick();
      tick();
      tick();
      bus.keys = 12'h000;
      tick();
      tick();
      tick();
      tick();
      check_val("rel_hold_note", {28'd0, bus.note}, 32'd9);
      tick();
      check_val("rel_note", {28'd0, bus.note}, 32'hF);
      check_val("rel_gate", {31'd0, bus.gate}, 32'd0);
      check_val("rel_stb",  {31'd0, bus.step_stb}, 32'd0);
      nstb = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (bus.step_stb === 1'b1) nstb++;
      end
      check_val("idle_no_stb", nstb, 32'd0);

      // Test 5: restart latency, tempo change mid-step, ena drop
      bus.keys = 12'h890;
      run_step(len, lows, lastg);
      check_val("restart_len",  len, 32'd2);
      check_val("restart_note", {28'd0, bus.note}, 32'd0);
      bus.tempo = 8'd3;
      step_check("tmp0", 4, 8, -1);
      step_check("tmp1", 7, 16, -1);
      for (int i = 0; i < 5; i++) tick();
      bus.ena = 1'b0;
      tick();
      check_val("ena_note", {28'd0, bus.note}, 32'hF);
      check_val("ena_gate", {31'd0, bus.gate}, 32'd0);
      check_val("ena_stb",  {31'd0, bus.step_stb}, 32'd0);

      // Test 6: octave behaviour with C,G in up mode
`ifdef OCTAVE_SPAN_EN
      oct6 = '{4, 5, 5, 4, 15, 15};
`else
      oct6 = '{4, 4, 4, 4, 15, 15};
`endif
      bus.tempo     = 8'd1;
      bus.octave_in = 4'd4;
      bus.keys      = 12'h810;
      bus.ena       = 1'b1;
      run_step(len, lows, lastg);
      check_val("oct_start_len",  len, 32'd2);
      check_val("oct_start_note", {28'd0, bus.note}, 32'd0);
      check_val("oct_start_oct",  {28'd0, bus.octave}, 32'd4);
      step_check("oct0", 7, 8, oct6[0]);
      step_check("oct1", 0, 8, oct6[1]);
      step_check("oct2", 7, 8, oct6[2]);
      step_check("oct3", 0, 8, oct6[3]);
      bus.octave_in = 4'd15;
      step_check("oct4", 7, 8, oct6[4]);
      step_check("oct5", 0, 8, oct6[5]);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
